// File: rtl/fft_input_buffer_if.sv
// Port bundle for the FFT input buffer: the upstream sample stream in, the parallel frame out.
// The master modport drives samples; the slave modport belongs to fft_input_buffer.
interface fft_input_buffer_if #(
  parameter int DATA_W = 16
);
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  frame_valid;
  logic [7:0]            frame_cnt;
  logic [2*DATA_W-1:0]   buf_data0_out;
  logic [2*DATA_W-1:0]   buf_data1_out;
  logic [2*DATA_W-1:0]   buf_data2_out;
  logic [2*DATA_W-1:0]   buf_data3_out;
  logic [2*DATA_W-1:0]   buf_data4_out;
  logic [2*DATA_W-1:0]   buf_data5_out;
  logic [2*DATA_W-1:0]   buf_data6_out;
  logic [2*DATA_W-1:0]   buf_data7_out;
  logic [2*DATA_W-1:0]   buf_data8_out;
  logic [2*DATA_W-1:0]   buf_data9_out;
  logic [2*DATA_W-1:0]   buf_data10_out;
  logic [2*DATA_W-1:0]   buf_data11_out;
  logic [2*DATA_W-1:0]   buf_data12_out;
  logic [2*DATA_W-1:0]   buf_data13_out;
  logic [2*DATA_W-1:0]   buf_data14_out;
  logic [2*DATA_W-1:0]   buf_data15_out;

  modport master (
    output in_valid, in_data,
    input  frame_valid, frame_cnt,
    input  buf_data0_out, buf_data1_out, buf_data2_out, buf_data3_out,
    input  buf_data4_out, buf_data5_out, buf_data6_out, buf_data7_out,
    input  buf_data8_out, buf_data9_out, buf_data10_out, buf_data11_out,
    input  buf_data12_out, buf_data13_out, buf_data14_out, buf_data15_out
  );

  modport slave (
    input  in_valid, in_data,
    output frame_valid, frame_cnt,
    output buf_data0_out, buf_data1_out, buf_data2_out, buf_data3_out,
    output buf_data4_out, buf_data5_out, buf_data6_out, buf_data7_out,
    output buf_data8_out, buf_data9_out, buf_data10_out, buf_data11_out,
    output buf_data12_out, buf_data13_out, buf_data14_out, buf_data15_out
  );
endinterface

// File: rtl/fft_input_buffer.sv
// Serial-to-parallel front end for the 16-point FFT: gathers 16 real samples into a frame
// and presents them as complex words {real, 16'h0000} in a separate, held output bank.
module fft_input_buffer #(
  parameter int DATA_W   = 16,
  parameter int N_POINTS = 16
) (
  input  logic              clk,
  input  logic              rst,
  fft_input_buffer_if.slave bus
);
  localparam int CNT_W  = $clog2(N_POINTS);
  localparam int WORD_W = 2 * DATA_W;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cap_q [N_POINTS-1];
  logic [DATA_W-1:0] cap_d [N_POINTS-1];
  logic [WORD_W-1:0] out_q [N_POINTS];
  logic [WORD_W-1:0] out_d [N_POINTS];
  logic              frame_valid_q, frame_valid_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  // Next-state: capture a sample, or on the last sample publish the whole frame at once.
  always_comb begin
    cnt_d         = cnt_q;
    cap_d         = cap_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (bus.in_valid) begin
      if (cnt_q == CNT_W'(N_POINTS - 1)) begin
        // The final sample goes straight to the last word; it never needs a capture slot.
        for (int k = 0; k < N_POINTS - 1; k++) begin
          out_d[k] = {cap_q[k], {DATA_W{1'b0}}};
        end
        out_d[N_POINTS-1] = {bus.in_data, {DATA_W{1'b0}}};
        cnt_d             = {CNT_W{1'b0}};
        frame_valid_d     = 1'b1;
        frame_cnt_d       = frame_cnt_q + 8'd1;
      end else begin
        for (int k = 0; k < N_POINTS - 1; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            cap_d[k] = bus.in_data;
          end else begin
            cap_d[k] = cap_q[k];
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset clears both banks and discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= {CNT_W{1'b0}};
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
      for (int k = 0; k < N_POINTS - 1; k++) begin
        cap_q[k] <= {DATA_W{1'b0}};
      end
      for (int k = 0; k < N_POINTS; k++) begin
        out_q[k] <= {WORD_W{1'b0}};
      end
    end else begin
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      cap_q         <= cap_d;
      out_q         <= out_d;
    end
  end

  assign bus.frame_valid    = frame_valid_q;
  assign bus.frame_cnt      = frame_cnt_q;
  assign bus.buf_data0_out  = out_q[0];
  assign bus.buf_data1_out  = out_q[1];
  assign bus.buf_data2_out  = out_q[2];
  assign bus.buf_data3_out  = out_q[3];
  assign bus.buf_data4_out  = out_q[4];
  assign bus.buf_data5_out  = out_q[5];
  assign bus.buf_data6_out  = out_q[6];
  assign bus.buf_data7_out  = out_q[7];
  assign bus.buf_data8_out  = out_q[8];
  assign bus.buf_data9_out  = out_q[9];
  assign bus.buf_data10_out = out_q[10];
  assign bus.buf_data11_out = out_q[11];
  assign bus.buf_data12_out = out_q[12];
  assign bus.buf_data13_out = out_q[13];
  assign bus.buf_data14_out = out_q[14];
  assign bus.buf_data15_out = out_q[15];
endmodule
